// File: rtl/spec_pkg.sv
// Shared encodings for the power-spectrum accumulator: modes, FSM states and
// the per-bin control word carried down the squaring pipeline.
package spec_pkg;

  localparam logic [1:0] MODE_INSTANT = 2'd0;
  localparam logic [1:0] MODE_AVG     = 2'd1;
  localparam logic [1:0] MODE_PEAK    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACC   = 2'd2
  } state_t;

  typedef struct packed {
    logic       first;
    logic       emit;
    logic       err;
    logic [1:0] mode;
    logic [3:0] n;
  } bin_ctl_t;

  function automatic logic [3:0] clamp_log2(input logic [3:0] n, input logic [3:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/spec_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module spec_acc_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WIDTH  = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/power_spec_accum.sv
// Per-bin power |X|^2 with instant, averaged or peak-hold integration over
// 2^n frames; results stream out on the final frame with fixed 4-cycle latency.
module power_spec_accum
  import spec_pkg::*;
#(
  parameter int unsigned DW           = 16,
  parameter int unsigned NFFT_LOG2    = 10,
  parameter int unsigned MAX_AVG_LOG2 = 4,
  parameter int unsigned OUT_W        = 2*DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  cfg_mode,
  input  logic [3:0]                  cfg_avg_log2,
  input  logic                        in_valid,
  input  logic signed [DW-1:0]        in_re,
  input  logic signed [DW-1:0]        in_im,
  input  logic [NFFT_LOG2-1:0]        in_index,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out_power,
  output logic [NFFT_LOG2-1:0]        out_index,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err_index
);

  localparam int unsigned SQ_W  = 2*DW;
  localparam int unsigned ACC_W = SQ_W + MAX_AVG_LOG2;
  localparam int unsigned FC_W  = MAX_AVG_LOG2 + 1;
  localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [3:0]            n_q;
  logic [FC_W-1:0]       frame_q, last_frame_q;
  logic [NFFT_LOG2-1:0]  exp_idx_q;

  logic                  start_ok_c, accept_bin_c, mismatch_c, last_bin_c, final_frame_c;
  logic [1:0]            mode_eff_c;
  logic [3:0]            n_eff_c;
  bin_ctl_t              s0_ctl_c;

  // Next-state logic and per-bin classification of the incoming strobe
  always_comb begin
    state_d       = state_q;
    mode_eff_c    = (cfg_mode == 2'd3) ? MODE_INSTANT : cfg_mode;
    n_eff_c       = (mode_eff_c == MODE_INSTANT) ? 4'd0
                                                 : clamp_log2(cfg_avg_log2, 4'(MAX_AVG_LOG2));
    start_ok_c    = start && (state_q == ST_IDLE);
    accept_bin_c  = in_valid && (state_q != ST_IDLE);
    mismatch_c    = accept_bin_c && (in_index != exp_idx_q);
    last_bin_c    = accept_bin_c && !mismatch_c && (exp_idx_q == LAST_IDX);
    final_frame_c = (frame_q == last_frame_q);
    s0_ctl_c.first = (state_q == ST_FIRST);
    s0_ctl_c.emit  = final_frame_c && !mismatch_c;
    s0_ctl_c.err   = mismatch_c;
    s0_ctl_c.mode  = mode_q;
    s0_ctl_c.n     = n_q;
    case (state_q)
      ST_IDLE: if (start_ok_c) state_d = ST_FIRST;
      ST_FIRST, ST_ACC: begin
        if (mismatch_c)      state_d = ST_IDLE;
        else if (last_bin_c) state_d = final_frame_c ? ST_IDLE : ST_ACC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy         <= 1'b0;
      mode_q       <= MODE_INSTANT;
      n_q          <= 4'd0;
      frame_q      <= '0;
      last_frame_q <= '0;
      exp_idx_q    <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      if (start_ok_c) begin
        mode_q       <= mode_eff_c;
        n_q          <= n_eff_c;
        last_frame_q <= (FC_W'(1) << n_eff_c) - FC_W'(1);
        frame_q      <= '0;
        exp_idx_q    <= '0;
      end else if (accept_bin_c) begin
        exp_idx_q <= exp_idx_q + NFFT_LOG2'(1);
        if (last_bin_c) frame_q <= frame_q + FC_W'(1);
      end
    end
  end

  logic                  s1_v, s2_v, s3_v;
  bin_ctl_t              s1_ctl, s2_ctl, s3_ctl;
  logic signed [DW-1:0]  s1_re, s1_im;
  logic [NFFT_LOG2-1:0]  s1_idx, s2_idx, s3_idx;
  logic [SQ_W-1:0]       s2_sq;
  logic [ACC_W-1:0]      s2_acc, s3_val, rd_data;
  logic signed [SQ_W-1:0] re_sq_c, im_sq_c;
  logic [SQ_W-1:0]       sq_c;
  logic [ACC_W-1:0]      new_c, shifted_c;
  logic [OUT_W-1:0]      sat_c;

  // RAM read is issued at acceptance so its data lines up with stage 1
  spec_acc_ram #(
    .ADDR_W (NFFT_LOG2),
    .WIDTH  (ACC_W)
  ) u_ram (
    .clk   (clk),
    .we    (s2_v && !s2_ctl.err),
    .waddr (s2_idx),
    .wdata (new_c),
    .raddr (in_index),
    .rdata (rd_data)
  );

  always_comb begin
    re_sq_c = SQ_W'(s1_re) * SQ_W'(s1_re);
    im_sq_c = SQ_W'(s1_im) * SQ_W'(s1_im);
    sq_c    = $unsigned(re_sq_c) + $unsigned(im_sq_c);
  end

  // First frame overwrites, so the RAM never needs clearing
  always_comb begin
    new_c = ACC_W'(s2_sq);
    if (!s2_ctl.first && (s2_ctl.mode == MODE_AVG)) begin
      new_c = s2_acc + ACC_W'(s2_sq);
    end else if (!s2_ctl.first && (s2_ctl.mode == MODE_PEAK) && (s2_acc > ACC_W'(s2_sq))) begin
      new_c = s2_acc;
    end
  end

  always_comb begin
    shifted_c = (s3_ctl.mode == MODE_AVG) ? (s3_val >> s3_ctl.n) : s3_val;
  end

  if (OUT_W >= ACC_W) begin : g_nosat
    always_comb sat_c = OUT_W'(shifted_c);
  end else begin : g_sat
    always_comb sat_c = (|shifted_c[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted_c[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s3_v       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_index  <= 1'b0;
      out_power  <= '0;
      out_index  <= '0;
    end else begin
      s1_v       <= accept_bin_c;
      s2_v       <= s1_v;
      s3_v       <= s2_v;
      out_valid  <= s3_v && s3_ctl.emit;
      frame_done <= s3_v && s3_ctl.emit && (s3_idx == LAST_IDX);
      err_index  <= s3_v && s3_ctl.err;
      if (s3_v && s3_ctl.emit) begin
        out_power <= sat_c;
        out_index <= s3_idx;
      end
    end
  end

  // Datapath registers; qualified by the valid bits above
  always_ff @(posedge clk) begin
    s1_ctl <= s0_ctl_c;
    s1_re  <= in_re;
    s1_im  <= in_im;
    s1_idx <= in_index;
    s2_ctl <= s1_ctl;
    s2_idx <= s1_idx;
    s2_sq  <= sq_c;
    s2_acc <= rd_data;
    s3_ctl <= s2_ctl;
    s3_idx <= s2_idx;
    s3_val <= new_c;
  end

endmodule

// File: tb/tb_power_spec_accum.sv
// Bench for power_spec_accum: table-driven integrations plus random runs,
// every output bin checked against a frame-level reference model.
module tb_power_spec_accum;

  localparam int DW = 16;
  localparam int NL = 10;
  localparam int ML = 4;
  localparam int OW = 32;
  localparam int NB = 1024;
  localparam longint SAT_MAX = 64'd4294967295;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           cfg_mode;
  logic [3:0]           cfg_avg_log2;
  logic                 in_valid;
  logic signed [DW-1:0] in_re, in_im;
  logic [NL-1:0]        in_index;
  logic                 out_valid;
  logic [OW-1:0]        out_power;
  logic [NL-1:0]        out_index;
  logic                 busy, frame_done, err_index;

  power_spec_accum #(
    .DW(DW), .NFFT_LOG2(NL), .MAX_AVG_LOG2(ML), .OUT_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .cfg_avg_log2(cfg_avg_log2), .in_valid(in_valid), .in_re(in_re),
    .in_im(in_im), .in_index(in_index), .out_valid(out_valid),
    .out_power(out_power), .out_index(out_index), .busy(busy),
    .frame_done(frame_done), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int     due;
    int     idx;
    longint pw;
    bit     fd;
    bit     err;
  } exp_t;

  typedef struct {
    int     mode;
    int     n_cfg;
    bit     ramp;
    int     tbin;
    int     tre[4];
    int     tim[4];
    longint exp_pw;
  } vec_t;

  exp_t   q[$];
  exp_t   mon_e;
  vec_t   tbl[6];
  int     re_d[16][NB];
  int     im_d[16][NB];
  longint exp_pw[NB];
  longint got_pw[NB];
  bit     got_seen[NB];
  int     z4[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Output monitor: every cycle either matches the next due entry or is quiet
  always @(posedge clk) begin
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e = q.pop_front();
      if (mon_e.err) begin
        chk("err_index", err_index, 1);
        chk("out_valid_on_err", out_valid, 0);
        chk("frame_done_on_err", frame_done, 0);
      end else begin
        chk("out_valid", out_valid, 1);
        chk("out_index", out_index, mon_e.idx);
        chk("out_power", out_power, mon_e.pw);
        chk("frame_done", frame_done, mon_e.fd);
        chk("err_index_quiet", err_index, 0);
        got_pw[mon_e.idx]   = out_power;
        got_seen[mon_e.idx] = 1'b1;
      end
    end else if (out_valid === 1'b1 || err_index === 1'b1 || frame_done === 1'b1) begin
      chk("spurious_output", {out_valid, err_index, frame_done}, 0);
    end
  end

  // One full integration: generate frames, model the result, drive, expect
  task automatic run(input int mode, input int n_cfg, input bit ramp, input int tbin,
                     input int tre[4], input int tim[4], input bit disturb,
                     input int rst_f, input int rst_b);
    int m, ne, nf;
    longint sq, acc;
    bit aborted;
    m  = (mode == 3) ? 0 : mode;
    ne = (m == 0) ? 0 : ((n_cfg > ML) ? ML : n_cfg);
    nf = 1 << ne;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < NB; k++) begin
        if (ramp) begin re_d[f][k] = k; im_d[f][k] = 0; end
        else begin re_d[f][k] = rand_val(); im_d[f][k] = rand_val(); end
        if (k == tbin) begin re_d[f][k] = tre[f % 4]; im_d[f][k] = tim[f % 4]; end
      end
    end
    for (int k = 0; k < NB; k++) begin
      acc = 0;
      for (int f = 0; f < nf; f++) begin
        sq = longint'(re_d[f][k]) * re_d[f][k] + longint'(im_d[f][k]) * im_d[f][k];
        if (m == 1)      acc = acc + sq;
        else if (m == 2) acc = (f == 0 || sq > acc) ? sq : acc;
        else             acc = sq;
      end
      if (m == 1) acc = acc / nf;
      if (acc > SAT_MAX) acc = SAT_MAX;
      exp_pw[k]   = acc;
      got_seen[k] = 1'b0;
    end

    @(posedge clk); #1;
    start = 1'b1; cfg_mode = 2'(mode); cfg_avg_log2 = 4'(n_cfg);
    aborted = 1'b0;
    for (int f = 0; f < nf && !aborted; f++) begin
      for (int k = 0; k < NB && !aborted; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (f == rst_f && k == rst_b) begin
          rst = 1'b1; in_valid = 1'b0;
          while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
          @(posedge clk); #1;
          rst = 1'b0;
          chk("busy_after_rst", busy, 0);
          chk("out_valid_after_rst", out_valid, 0);
          aborted = 1'b1;
        end else begin
          in_valid = 1'b1;
          in_re    = 16'(re_d[f][k]);
          in_im    = 16'(im_d[f][k]);
          in_index = 10'(k);
          if (f == nf - 1)
            q.push_back('{due: cyc + 4, idx: k, pw: exp_pw[k], fd: (k == NB - 1), err: 1'b0});
          if (disturb && f == 0 && k == 100) begin
            start = 1'b1; cfg_mode = (m == 2) ? 2'd1 : 2'd2; cfg_avg_log2 = 4'd3;
          end
          if (f == 0 && k == 512) chk("busy_mid_run", busy, 1);
        end
      end
    end
    if (!aborted) begin
      @(posedge clk); #1;
      in_valid = 1'b0; start = 1'b0;
      chk("busy_after_last", busy, 0);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("pending_outputs", q.size(), 0);
    q.delete();
  endtask

  // Index skip 7 -> 9 in an instant run
  task automatic skip_test();
    int r, i;
    longint sq;
    @(posedge clk); #1;
    start = 1'b1; cfg_mode = 2'd0; cfg_avg_log2 = 4'd0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      r = rand_val(); i = rand_val();
      sq = longint'(r) * r + longint'(i) * i;
      in_valid = 1'b1; in_re = 16'(r); in_im = 16'(i);
      in_index = (k == 8) ? 10'd9 : 10'(k);
      if (k < 8) q.push_back('{due: cyc + 4, idx: k, pw: sq, fd: 1'b0, err: 1'b0});
      else       q.push_back('{due: cyc + 4, idx: 9, pw: 0, fd: 1'b0, err: 1'b1});
    end
    @(posedge clk); #1;
    in_index = 10'd10;
    chk("busy_after_skip", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pending_after_skip", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = 2'd0; cfg_avg_log2 = 4'd0;
    in_valid = 1'b0; in_re = '0; in_im = '0; in_index = '0;

    tbl[0] = '{mode: 0, n_cfg: 3, ramp: 1, tbin: 1023, tre: '{1023, 0, 0, 0}, tim: '{0, 0, 0, 0}, exp_pw: 1046529};
    tbl[1] = '{mode: 1, n_cfg: 2, ramp: 0, tbin: 10, tre: '{100, 200, 300, 400}, tim: '{0, 0, 0, 0}, exp_pw: 75000};
    tbl[2] = '{mode: 2, n_cfg: 1, ramp: 0, tbin: 5, tre: '{-32768, 10, 0, 0}, tim: '{-32768, 10, 0, 0}, exp_pw: 64'd2147483648};
    tbl[3] = '{mode: 1, n_cfg: 9, ramp: 0, tbin: 600, tre: '{1, 2, 3, 4}, tim: '{0, 0, 0, 0}, exp_pw: 7};
    tbl[4] = '{mode: 3, n_cfg: 2, ramp: 0, tbin: 0, tre: '{-5, -5, -5, -5}, tim: '{12, 12, 12, 12}, exp_pw: 169};
    tbl[5] = '{mode: 1, n_cfg: 0, ramp: 0, tbin: 1023, tre: '{3, 3, 3, 3}, tim: '{4, 4, 4, 4}, exp_pw: 25};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_out_power", out_power, 0);
    chk("rst_out_index", out_index, 0);
    rst = 1'b0;

    // Average run killed by reset partway through frame 1
    run(1, 2, 1'b0, -1, z4, z4, 1'b0, 1, 300);

    for (int t = 0; t < 6; t++) begin
      run(tbl[t].mode, tbl[t].n_cfg, tbl[t].ramp, tbl[t].tbin, tbl[t].tre, tbl[t].tim,
          1'b0, -1, -1);
      chk($sformatf("tbl%0d_seen", t), got_seen[tbl[t].tbin], 1);
      chk($sformatf("tbl%0d_power", t), got_pw[tbl[t].tbin], tbl[t].exp_pw);
    end

    skip_test();

    // Reset during the final (instant) frame aborts the remaining outputs
    run(0, 0, 1'b1, -1, z4, z4, 1'b0, 0, 300);

    // Start pulse and config change while busy are ignored
    run(1, 1, 1'b0, -1, z4, z4, 1'b1, -1, -1);
    run(2, 2, 1'b0, -1, z4, z4, 1'b1, -1, -1);

    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, -1, z4, z4,
          1'b0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/power_spec_accum.md
POWER_SPEC_ACCUM -- requirements
Module: power_spec_accum

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed FFT bin component width.
REQ-002 SHALL have parameter NFFT_LOG2, default 10, meaning log2 of FFT length (bins per frame).
REQ-003 SHALL have parameter MAX_AVG_LOG2, default 4, meaning log2 of the maximum frames per integration.
REQ-004 SHALL have parameter OUT_W, default 2*DW, meaning output power width.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: start  in  1  one-cycle arm pulse; cfg_mode  in  2  0=instant, 1=average, 2=peak-hold, 3=reserved (treated as 0).
REQ-008 SHALL have ports: cfg_avg_log2  in  4  frames per integration = 2^n, clamped to MAX_AVG_LOG2; in_valid  in  1  bin strobe.
REQ-009 SHALL have ports: in_re, in_im  in  DW  signed bin value; in_index  in  NFFT_LOG2  bin index.
REQ-010 SHALL have ports: out_valid  out  1; out_power  out  OUT_W  unsigned; out_index  out  NFFT_LOG2.
REQ-011 SHALL have ports: busy  out  1  integration armed; frame_done  out  1  pulse on last output bin; err_index  out  1  pulse on index mismatch.

Function
REQ-012 SHALL latch cfg_mode and clamped cfg_avg_log2 on an accepted start; later config changes SHALL NOT affect the running integration.
REQ-013 SHALL use FSM states IDLE, FIRST, ACC: IDLE--start-->FIRST; FIRST/ACC --bin NFFT-1 accepted--> ACC if frames remain, else IDLE.
REQ-014 SHALL treat instant mode as one frame regardless of cfg_avg_log2.
REQ-015 SHALL ignore in_valid while IDLE and ignore start while busy.
REQ-016 SHALL compute sq = re*re + im*im as unsigned 2*DW bits with no truncation (max 2^(2*DW-1)).
REQ-017 SHALL keep a 2^NFFT_LOG2-entry accumulator RAM, width 2*DW+MAX_AVG_LOG2, one-cycle registered read, addressed by in_index.
REQ-018 SHALL in FIRST write sq unconditionally (no read-dependent value); in ACC write acc+sq (average) or max(acc,sq) (peak-hold).
REQ-019 SHALL assert out_valid exactly 4 cycles after the accepting in_valid, only during the final frame, with out_index = that in_index.
REQ-020 SHALL output average as acc >> n (truncating), peak-hold as max value, instant as sq; saturate to 2^OUT_W-1 if wider than OUT_W.
REQ-021 SHALL pulse frame_done in the same cycle as out_valid for index NFFT-1 of the final frame.
REQ-022 SHALL track an expected-index counter reset to 0 per frame; if an accepted in_index differs, pulse err_index 4 cycles later, suppress that output, and return to IDLE without frame_done.
REQ-023 SHALL accept back-to-back bins every cycle and back-to-back frames (bin 0 immediately after bin NFFT-1) without stall; consecutive bins never share an address, so no RAM read/write hazard exists.
REQ-024 SHALL drain the 4-stage pipeline after returning to IDLE so the final bins still emit.
REQ-025 SHALL deassert busy in the cycle after bin NFFT-1 of the final frame is accepted.

Reset
REQ-026 SHALL on rst force FSM to IDLE, clear frame and index counters, and clear all pipeline valid bits.
REQ-027 SHALL reset out_valid, frame_done, err_index, busy to 0 and out_power, out_index to 0.
REQ-028 SHALL NOT clear the accumulator RAM; FIRST-frame overwrite guarantees correctness.
REQ-029 SHALL abort an integration on rst mid-frame with no further out_valid.

Structure
REQ-030 SHALL place mode encodings (MODE_INSTANT/AVG/PEAK) and FSM state encodings in shared package spec_pkg.
REQ-031 SHALL implement the RAM as sub-module spec_acc_ram (simple dual-port, sync read, inferable block RAM).
REQ-032 SHALL keep the squaring/summing pipeline inline in power_spec_accum.

Verification
REQ-033 Instant, NFFT=1024, bin k: re=k, im=0 -> out_power=k*k at out_index=k, 4-cycle latency, frame_done at k=1023.
REQ-034 Average, n=2, four frames with re=100,200,300,400, im=0 -> out_power=(10000+40000+90000+160000)>>2=75000, outputs only in frame 4.
REQ-035 Peak-hold, n=1, bin 5 re=-32768/im=-32768 in frame 1, 10/10 in frame 2 -> bin 5 out_power=2147483648.
REQ-036 Index skip 7->9 in frame 1 -> err_index pulse, no out_valid for bin 9, busy=0, no frame_done.
REQ-037 rst asserted at bin 300 of an average run, then start and a fresh run -> correct results, no stale accumulator contribution.
REQ-038 start while busy and cfg_mode change mid-run -> ignored; result matches originally latched config.
